// File: rtl/apb_slave_responder_pkg.sv
// apb_slave_responder_pkg: shared widths and enums for the APB slave responder
// Contents: bus widths, FSM state enum, slave error enum, transfer type enum.
package apb_slave_responder_pkg;
   localparam int ADDRESS_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} operation_states_e;
   typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} slave_error_e;
   typedef enum logic {READ = 1'b0, WRITE = 1'b1} tx_type_e;
endpackage

// File: rtl/apb_slave_responder_if.sv
// apb_slave_responder_if: APB pin bundle between one master and this slave
// master: drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot, receives pready/prdata/pslverr
// slave: the mirror image of master
interface apb_slave_responder_if
   import apb_slave_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH = apb_slave_responder_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH = apb_slave_responder_pkg::DATA_WIDTH
);
   logic psel;
   logic penable;
   logic pwrite;
   logic [ADDRESS_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [2:0] pprot;
   logic pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic pslverr;
   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input pready, prdata, pslverr
   );
   modport slave (
      input psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_slave_mem_array.sv
// apb_slave_mem_array: byte-strobed register memory, async-reset clear, combinational read
// pclk/preset_n: clock and async active-low reset (clears every word)
// we: per-byte write enable for word waddr, wdata: write data
// raddr/rdata: combinational read port
module apb_slave_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH = 16,
   parameter int INDEX_WIDTH = 4
) (
   input logic pclk,
   input logic preset_n,
   input logic [DATA_WIDTH/8-1:0] we,
   input logic [INDEX_WIDTH-1:0] waddr,
   input logic [DATA_WIDTH-1:0] wdata,
   input logic [INDEX_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int w = 0; w < MEM_DEPTH; w++) mem[w] <= '0;
      end else begin
         for (int b = 0; b < DATA_WIDTH/8; b++)
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/apb_slave_responder.sv
// apb_slave_responder: APB slave with byte-strobed memory, wait states and error response
// pclk/preset_n: clock and async active-low reset
// bus: APB slave modport (psel is this slave's pselx bit); outputs are registered
module apb_slave_responder
   import apb_slave_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH = apb_slave_responder_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH = apb_slave_responder_pkg::DATA_WIDTH,
   parameter int MEM_DEPTH = 16,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0,
   parameter int WAIT_STATES = 1,
   parameter int SECURE_ONLY = 0
) (
   input logic pclk,
   input logic preset_n,
   apb_slave_responder_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // one bit wider than the address so the end of the window cannot wrap
   localparam logic [ADDRESS_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(MEM_DEPTH * NB);
   localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(NB - 1);
   operation_states_e state, bus_phase;
   tx_type_e tx_q, r_tx;
   logic err_q, s_err, r_err, start, counting, respond;
   logic [IW-1:0] idx_q, s_idx, r_idx;
   logic [DATA_WIDTH-1:0] wdata_q, mem_rdata;
   logic [NB-1:0] strb_q, mem_we;
   logic [3:0] wait_cnt;
   // a setup phase on the pins always starts a new transfer, aborting any unfinished one
   assign bus_phase = !bus.psel ? IDLE : bus.penable ? ACCESS : SETUP;
   assign start = bus_phase == SETUP;
   assign s_err = bus.paddr < BASE_ADDR || {1'b0, bus.paddr} >= END_ADDR ||
                  (bus.paddr & LANE_MASK) != '0 || (SECURE_ONLY != 0 && bus.pprot[1]);
   assign s_idx = IW'((bus.paddr - BASE_ADDR) >> LB);
   // with no wait states the response is built from the pins at the setup edge itself
   assign r_err = start ? s_err : err_q;
   assign r_tx = start ? tx_type_e'(bus.pwrite) : tx_q;
   assign r_idx = start ? s_idx : idx_q;
   assign counting = state == ACCESS && bus_phase == ACCESS && !bus.pready;
   assign respond = start ? WAIT_STATES == 0 : counting && wait_cnt == 4'd1;
   // memory is written on the edge that ends the pready cycle, only if the master is still there
   assign mem_we = (state == ACCESS && bus.pready && bus_phase == ACCESS && tx_q == WRITE && !err_q) ? strb_q : '0;
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state <= IDLE;
         wait_cnt <= '0;
         tx_q <= READ;
         err_q <= 1'b0;
         idx_q <= '0;
         wdata_q <= '0;
         strb_q <= '0;
         bus.pready <= 1'b0;
         bus.prdata <= '0;
         bus.pslverr <= OKAY;
      end else begin
         bus.pready <= 1'b0;
         bus.prdata <= '0;
         bus.pslverr <= OKAY;
         if (start) begin
            state <= ACCESS;
            wait_cnt <= 4'(WAIT_STATES);
            tx_q <= r_tx;
            err_q <= s_err;
            idx_q <= s_idx;
            wdata_q <= bus.pwdata;
            strb_q <= bus.pstrb;
         end else if (counting) begin
            wait_cnt <= wait_cnt - 4'd1;
         end else begin
            state <= IDLE;
            wait_cnt <= '0;
         end
         if (respond) begin
            bus.pready <= 1'b1;
            bus.pslverr <= r_err ? ERROR : OKAY;
            bus.prdata <= (r_err || r_tx == WRITE) ? '0 : mem_rdata;
         end
      end
   end
   apb_slave_mem_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .MEM_DEPTH(MEM_DEPTH),
      .INDEX_WIDTH(IW)
   ) u_mem (
      .pclk(pclk),
      .preset_n(preset_n),
      .we(mem_we),
      .waddr(idx_q),
      .wdata(wdata_q),
      .raddr(r_idx),
      .rdata(mem_rdata)
   );
endmodule

// File: doc/apb_slave_responder.md
# apb_slave_responder

Synthesizable APB slave target that sits directly downstream of the master agent's pin interface. It responds to transfers addressed to it through one bit of `pselx`. It holds a small byte-strobed register memory, inserts a parameterised number of wait states, and raises `pslverr` for out-of-range, misaligned or protection-violating accesses. It is the DUT counterpart the slave agent monitors, and it uses the widths and enums from the global package.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, paddr width (package value).
- `DATA_WIDTH`, 32, pwdata/prdata width; must be 8, 16 or 32.
- `MEM_DEPTH`, 16, number of DATA_WIDTH-wide words.
- `BASE_ADDR`, 0, byte address of word 0.
- `WAIT_STATES`, 1, access-phase cycles with pready low; range 0..15.
- `SECURE_ONLY`, 0, when 1, non-secure accesses (pprot[1]=1) are errored.

Ports (clock and reset: single clock; reset is asynchronous, active-low):
- `pclk` in 1: clock.
- `preset_n` in 1: asynchronous active-low reset.
- `psel` in 1: this slave's bit of pselx.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 write, 0 read (tx_type_e).
- `paddr` in ADDRESS_WIDTH: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `pstrb` in DATA_WIDTH/8: write byte lanes.
- `pprot` in 3: protection type.
- `pready` out 1: transfer completes this cycle.
- `prdata` out DATA_WIDTH: read data; valid only while pready=1.
- `pslverr` out 1: slave_error_e; valid only while pready=1.

## Operation
- FSM states are IDLE, SETUP and ACCESS (operation_states_e).
- **IDLE**
  - psel=1, penable=0 → SETUP.
  - psel=1, penable=1 without a prior setup is a protocol violation: ignore it and stay in IDLE.
- **SETUP**
  - Capture paddr, pwrite, pwdata, pstrb and pprot.
  - Load `wait_cnt` = WAIT_STATES.
  - Compute `err`, which is set when any of the following holds:
    - paddr < BASE_ADDR;
    - paddr ≥ BASE_ADDR + MEM_DEPTH*(DATA_WIDTH/8);
    - paddr low log2(DATA_WIDTH/8) bits are nonzero;
    - SECURE_ONLY is 1 and pprot[1]=1.
  - Always go to ACCESS on the next edge.
- **ACCESS**
  - While wait_cnt>0: decrement wait_cnt; pready=0.
  - When wait_cnt reaches 0: pready=1 for exactly one cycle.
    - Write with err=0: at the completing edge, update each byte lane i where pstrb[i]=1; other lanes hold.
    - Read with err=0: prdata = mem[(paddr-BASE_ADDR)/(DATA_WIDTH/8)].
    - err=1: pslverr=1, prdata=0, memory unchanged.
  - After completion, next state is SETUP if psel=1 and penable=0 on the following cycle, otherwise IDLE.
- **Abort:** psel or penable deasserted while in ACCESS before completion → return to IDLE; no memory update; outputs go to 0.
- Address index arithmetic is done in ADDRESS_WIDTH bits; the upper-bound comparison must not overflow (compute in ADDRESS_WIDTH+1 bits).

## Timing
- Reset, asynchronous on preset_n=0:
  - FSM → IDLE;
  - pready=0, pslverr=0, prdata=0;
  - all memory words = 0;
  - wait_cnt=0.
- Reset asserted mid-transfer discards the transfer and does not write memory.
- Outputs are registered.
- With the setup phase in cycle T:
  - pready=1 in cycle T+1+WAIT_STATES;
  - write data is visible to a read issued in the next transfer.
- Back-to-back transfers: minimum period is 2+WAIT_STATES cycles; no idle cycle is required between them.
- Outside the pready=1 cycle, pslverr=0 and prdata=0.

## Structure
- Shared package holds:
  - operation_states_e (re-enabled);
  - ADDRESS_WIDTH and DATA_WIDTH;
  - slave_error_e and tx_type_e.
- One sub-module, `apb_slave_mem_array`:
  - MEM_DEPTH×DATA_WIDTH flops with async-reset clear;
  - per-byte write enable;
  - combinational read port.
- The FSM, wait counter and decode/err logic live in the top module.

## Test plan
- Reset → pready=0, pslverr=0, prdata=0; then read 0x0 with WAIT_STATES=1 → pready high 2 cycles after setup, prdata=0x0, pslverr=0.
- Write 0x0000_0004 data 0xDEADBEEF pstrb=4'b1111, then write same addr data 0x11223344 pstrb=4'b0101, then read → 0xDE22BE44.
- Read 0x40 (beyond 16 words) → pslverr=1, prdata=0; write 0x3 (misaligned) → pslverr=1, memory unchanged on readback.
- WAIT_STATES=0 back-to-back writes to 0x0/0x4/0x8 → pready each second cycle, all three readable.
- SECURE_ONLY=1, pprot=3'b010 write → pslverr=1; same write with pprot=3'b000 → OK.
- Assert preset_n low during ACCESS of a write → no update, outputs 0 immediately; psel dropped mid-wait → FSM back to IDLE, no write.
